// File: rtl/lpc_io_decode_pkg.sv
// Shared definitions for the LPC I/O-cycle target: FSM encoding and LPC nibble constants.
package lpc_io_decode_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCycType,
        StAddr0,
        StAddr1,
        StAddr2,
        StAddr3,
        StData0,
        StData1,
        StHtar0,
        StHtar1,
        StSync,
        StRdata0,
        StRdata1,
        StPtar0,
        StPtar1
    } lpc_state_e;

    localparam logic [3:0]  LAD_START   = 4'h0;
    localparam logic [2:0]  CYC_IO_RD   = 3'b000;
    localparam logic [2:0]  CYC_IO_WR   = 3'b001;
    localparam logic [3:0]  SYNC_READY  = 4'h0;
    localparam logic [3:0]  LAD_IDLE    = 4'hF;
    localparam logic [15:0] PORT80_ADDR = 16'h0080;

endpackage

// File: rtl/lpc_io_decode.sv
// LPC I/O-cycle target: decodes host nibbles, claims a 256-byte BAR and strobes the register map.
// Optional port 80 write snooping is enabled by defining LPC_PORT80_EN.
module lpc_io_decode
    import lpc_io_decode_pkg::*;
#(
    parameter logic [7:0] IO_BAR = 8'h08
) (
    input  logic        Mclk,
    input  logic        MainReset,
    input  logic        LFrameN,
    input  logic [3:0]  LadIn,
    output logic [3:0]  LadOut,
    output logic        LadOe,
    output logic [15:0] DevAddr,
    output logic        RdDev_En,
    output logic        WrDev_En,
    output logic [7:0]  WrDev_Data,
    input  logic [7:0]  RdDev_Data
`ifdef LPC_PORT80_EN
    ,
    output logic [7:0]  Port80Data
`endif
);

    lpc_state_e  state_q, state_d;
    logic [15:0] dev_addr_q, dev_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_hold_q, rd_hold_d;
    logic        is_wr_q, is_wr_d;
    logic        claim_q, claim_d;
`ifdef LPC_PORT80_EN
    logic        snoop_q, snoop_d;
    logic [7:0]  port80_q, port80_d;
    logic        addr_is_p80;
`endif

    always_comb begin
        state_d    = state_q;
        dev_addr_d = dev_addr_q;
        wr_data_d  = wr_data_q;
        rd_hold_d  = rd_hold_q;
        is_wr_d    = is_wr_q;
        claim_d    = claim_q;
`ifdef LPC_PORT80_EN
        snoop_d     = snoop_q;
        port80_d    = port80_q;
        addr_is_p80 = 1'b0;
`endif
        // A low LFrameN always wins: it starts a new cycle or aborts the current one.
        if (!LFrameN) begin
            state_d = (LadIn == LAD_START) ? StCycType : StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StIdle;
                StCycType: begin
                    if (LadIn[3:1] == CYC_IO_RD) begin
                        is_wr_d = 1'b0;
                        state_d = StAddr0;
                    end else if (LadIn[3:1] == CYC_IO_WR) begin
                        is_wr_d = 1'b1;
                        state_d = StAddr0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StAddr0: begin
                    dev_addr_d[15:12] = LadIn;
                    state_d           = StAddr1;
                end
                StAddr1: begin
                    dev_addr_d[11:8] = LadIn;
                    state_d          = StAddr2;
                end
                StAddr2: begin
                    dev_addr_d[7:4] = LadIn;
                    state_d         = StAddr3;
                end
                StAddr3: begin
                    dev_addr_d[3:0] = LadIn;
                    claim_d         = (dev_addr_q[15:8] == IO_BAR);
`ifdef LPC_PORT80_EN
                    addr_is_p80 = ({dev_addr_q[15:4], LadIn} == PORT80_ADDR);
                    snoop_d     = is_wr_q && addr_is_p80;
                    // A snooped write is never answered, even if the BAR also covers it.
                    if (snoop_d) begin
                        claim_d = 1'b0;
                    end
                    if (claim_d || snoop_d) begin
                        state_d = is_wr_q ? StData0 : StHtar0;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    if (claim_d) begin
                        state_d = is_wr_q ? StData0 : StHtar0;
                    end else begin
                        state_d = StIdle;
                    end
`endif
                end
                StData0: begin
                    wr_data_d[3:0] = LadIn;
                    state_d        = StData1;
                end
                StData1: begin
                    wr_data_d[7:4] = LadIn;
                    state_d        = StHtar0;
                end
                StHtar0: begin
`ifdef LPC_PORT80_EN
                    if (snoop_q) begin
                        port80_d = wr_data_q;
                    end
`endif
                    state_d = StHtar1;
                end
                StHtar1: state_d = claim_q ? StSync : StIdle;
                StSync: begin
                    // Register map data has long settled by now; hold it for both nibbles.
                    if (!is_wr_q) begin
                        rd_hold_d = RdDev_Data;
                    end
                    state_d = is_wr_q ? StPtar0 : StRdata0;
                end
                StRdata0: state_d = StRdata1;
                StRdata1: state_d = StPtar0;
                StPtar0:  state_d = StPtar1;
                StPtar1:  state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Mclk) begin
        if (MainReset) begin
            state_q    <= StIdle;
            dev_addr_q <= 16'h0000;
            wr_data_q  <= 8'hFF;
            rd_hold_q  <= 8'h00;
            is_wr_q    <= 1'b0;
            claim_q    <= 1'b0;
`ifdef LPC_PORT80_EN
            snoop_q    <= 1'b0;
            port80_q   <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            dev_addr_q <= dev_addr_d;
            wr_data_q  <= wr_data_d;
            rd_hold_q  <= rd_hold_d;
            is_wr_q    <= is_wr_d;
            claim_q    <= claim_d;
`ifdef LPC_PORT80_EN
            snoop_q    <= snoop_d;
            port80_q   <= port80_d;
`endif
        end
    end

    always_comb begin
        LadOut = LAD_IDLE;
        LadOe  = 1'b0;
        case (state_q)
            StSync: begin
                LadOut = SYNC_READY;
                LadOe  = 1'b1;
            end
            StRdata0: begin
                LadOut = rd_hold_q[3:0];
                LadOe  = 1'b1;
            end
            StRdata1: begin
                LadOut = rd_hold_q[7:4];
                LadOe  = 1'b1;
            end
            StPtar0: begin
                LadOut = LAD_IDLE;
                LadOe  = 1'b1;
            end
            default: begin
                LadOut = LAD_IDLE;
                LadOe  = 1'b0;
            end
        endcase
    end

    assign RdDev_En   = (state_q == StHtar0) && claim_q && !is_wr_q;
    assign WrDev_En   = (state_q == StHtar0) && claim_q && is_wr_q;
    assign DevAddr    = dev_addr_q;
    assign WrDev_Data = wr_data_q;
`ifdef LPC_PORT80_EN
    assign Port80Data = port80_q;
`endif

endmodule

// File: tb/tb_lpc_io_decode.sv
// Scoreboard bench for lpc_io_decode: stimulus queues expected strobes/LAD nibbles, monitor checks.
module tb_lpc_io_decode;

    logic        Mclk;
    logic        MainReset;
    logic        LFrameN;
    logic [3:0]  LadIn;
    logic [3:0]  LadOut;
    logic        LadOe;
    logic [15:0] DevAddr;
    logic        RdDev_En;
    logic        WrDev_En;
    logic [7:0]  WrDev_Data;
    logic [7:0]  RdDev_Data;
`ifdef LPC_PORT80_EN
    logic [7:0]  Port80Data;
`endif

    lpc_io_decode #(.IO_BAR(8'h08)) dut (
        .Mclk       (Mclk),
        .MainReset  (MainReset),
        .LFrameN    (LFrameN),
        .LadIn      (LadIn),
        .LadOut     (LadOut),
        .LadOe      (LadOe),
        .DevAddr    (DevAddr),
        .RdDev_En   (RdDev_En),
        .WrDev_En   (WrDev_En),
        .WrDev_Data (WrDev_Data),
        .RdDev_Data (RdDev_Data)
`ifdef LPC_PORT80_EN
        ,
        .Port80Data (Port80Data)
`endif
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } stb_t;

    typedef struct {
        logic [3:0] lad;
        int         cyc;
    } lad_t;

    stb_t stb_q[$];
    lad_t lad_q[$];

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          strobe_cnt = 0;
    int          oe_cnt = 0;
    logic [7:0]  map_val = 8'h00;

    initial begin
        Mclk = 1'b0;
        forever #15 Mclk = ~Mclk;
    end

    always @(posedge Mclk) cyc_cnt <= cyc_cnt + 1;

    // Register map model: data appears one cycle after the read strobe.
    always @(posedge Mclk) begin
        if (RdDev_En) RdDev_Data <= map_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge Mclk) begin
        stb_t e;
        lad_t l;
        if (RdDev_En && WrDev_En) chk("strobe_exclusive", 32'd1, 32'd0);
        if (RdDev_En || WrDev_En) begin
            strobe_cnt++;
            if (stb_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, WrDev_En, RdDev_En}, 32'd0);
            end else begin
                e = stb_q.pop_front();
                chk("stb_kind", {31'd0, WrDev_En}, {31'd0, e.is_wr});
                chk("stb_cycle", cyc_cnt, e.cyc);
                chk("stb_addr", {16'd0, DevAddr}, {16'd0, e.addr});
                if (e.is_wr) chk("stb_wdata", {24'd0, WrDev_Data}, {24'd0, e.data});
            end
        end
        if (LadOe) begin
            oe_cnt++;
            if (lad_q.size() == 0) begin
                chk("unexpected_lad_oe", {31'd0, LadOe}, 32'd0);
            end else begin
                l = lad_q.pop_front();
                chk("lad_cycle", cyc_cnt, l.cyc);
                chk("lad_value", {28'd0, LadOut}, {28'd0, l.lad});
            end
        end
    end

    task automatic cyc(input logic frame_n, input logic [3:0] lad);
        LFrameN = frame_n;
        LadIn   = lad;
        @(posedge Mclk);
        #1;
    endtask

    task automatic lpc_write(input logic [15:0] a, input logic [7:0] d, input bit claim);
        int s;
        cyc(1'b0, 4'h0);
        s = cyc_cnt;
        if (claim) begin
            stb_q.push_back('{is_wr: 1'b1, addr: a, data: d, cyc: s + 7});
            lad_q.push_back('{lad: 4'h0, cyc: s + 9});
            lad_q.push_back('{lad: 4'hF, cyc: s + 10});
        end
        cyc(1'b1, 4'h2);
        cyc(1'b1, a[15:12]);
        cyc(1'b1, a[11:8]);
        cyc(1'b1, a[7:4]);
        cyc(1'b1, a[3:0]);
        cyc(1'b1, d[3:0]);
        cyc(1'b1, d[7:4]);
        repeat (5) cyc(1'b1, 4'hF);
    endtask

    // full=0 stops after host turnaround, leaving only SYNC and RDATA0 expected.
    task automatic lpc_read(input logic [15:0] a, input logic [7:0] d, input bit claim,
                            input bit full);
        int s;
        map_val = d;
        cyc(1'b0, 4'h0);
        s = cyc_cnt;
        if (claim) begin
            stb_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00, cyc: s + 5});
            lad_q.push_back('{lad: 4'h0, cyc: s + 7});
            lad_q.push_back('{lad: d[3:0], cyc: s + 8});
            if (full) begin
                lad_q.push_back('{lad: d[7:4], cyc: s + 9});
                lad_q.push_back('{lad: 4'hF, cyc: s + 10});
            end
        end
        cyc(1'b1, 4'h0);
        cyc(1'b1, a[15:12]);
        cyc(1'b1, a[11:8]);
        cyc(1'b1, a[7:4]);
        cyc(1'b1, a[3:0]);
        cyc(1'b1, 4'hF);
        cyc(1'b1, 4'hF);
        if (full) repeat (5) cyc(1'b1, 4'hF);
    endtask

    initial begin
        int sc;
        int oc;
        MainReset  = 1'b1;
        LFrameN    = 1'b1;
        LadIn      = 4'hF;
        RdDev_Data = 8'h00;
        repeat (3) cyc(1'b1, 4'hF);
        MainReset = 1'b0;
        cyc(1'b1, 4'hF);
        chk("rst_lad_oe", {31'd0, LadOe}, 32'd0);
        chk("rst_lad_out", {28'd0, LadOut}, 32'hF);
        chk("rst_dev_addr", {16'd0, DevAddr}, 32'h0);
        chk("rst_wr_data", {24'd0, WrDev_Data}, 32'hFF);
        chk("rst_rd_en", {31'd0, RdDev_En}, 32'd0);
        chk("rst_wr_en", {31'd0, WrDev_En}, 32'd0);
`ifdef LPC_PORT80_EN
        chk("rst_port80", {24'd0, Port80Data}, 32'h00);
`endif

        lpc_write(16'h0805, 8'h3C, 1'b1);
        chk("wr_oe_released", {31'd0, LadOe}, 32'd0);
        chk("wr_addr_hold", {16'd0, DevAddr}, 32'h0805);
        chk("wr_data_hold", {24'd0, WrDev_Data}, 32'h3C);

        lpc_read(16'h0800, 8'hA5, 1'b1, 1'b1);
        chk("rd_oe_released", {31'd0, LadOe}, 32'd0);

        sc = strobe_cnt;
        oc = oe_cnt;
        lpc_read(16'h0900, 8'h11, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 4'hF);
        chk("unclaimed_strobes", strobe_cnt, sc);
        chk("unclaimed_oe", oe_cnt, oc);
        chk("unclaimed_addr", {16'd0, DevAddr}, 32'h0900);
        lpc_write(16'h0812, 8'hC3, 1'b1);

        // Memory-read cycle type: address nibbles must be ignored.
        sc = strobe_cnt;
        cyc(1'b0, 4'h0);
        cyc(1'b1, 4'h4);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h8);
        cyc(1'b1, 4'h3);
        cyc(1'b1, 4'h3);
        repeat (8) cyc(1'b1, 4'hF);
        chk("memcyc_addr", {16'd0, DevAddr}, 32'h0812);
        chk("memcyc_strobes", strobe_cnt, sc);

        // Abort during ADDR2, then an immediate new START.
        sc = strobe_cnt;
        cyc(1'b0, 4'h0);
        cyc(1'b1, 4'h2);
        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h8);
        cyc(1'b0, 4'hF);
        lpc_write(16'h0807, 8'h5A, 1'b1);
        chk("abort_strobes", strobe_cnt, sc + 1);

        // LFrameN held low: the last nibble (START) decides.
        cyc(1'b0, 4'hF);
        cyc(1'b0, 4'h3);
        lpc_write(16'h08A0, 8'h96, 1'b1);

        lpc_read(16'h0801, 8'h99, 1'b1, 1'b0);
        cyc(1'b1, 4'hF);
        MainReset = 1'b1;
        cyc(1'b1, 4'hF);
        chk("midrst_lad_oe", {31'd0, LadOe}, 32'd0);
        chk("midrst_lad_out", {28'd0, LadOut}, 32'hF);
        chk("midrst_dev_addr", {16'd0, DevAddr}, 32'h0);
        chk("midrst_wr_data", {24'd0, WrDev_Data}, 32'hFF);
        MainReset = 1'b0;
        repeat (2) cyc(1'b1, 4'hF);
        lpc_read(16'h08FF, 8'h3E, 1'b1, 1'b1);

`ifdef LPC_PORT80_EN
        sc = strobe_cnt;
        oc = oe_cnt;
        lpc_write(16'h0080, 8'h7E, 1'b0);
        chk("p80_data", {24'd0, Port80Data}, 32'h7E);
        chk("p80_strobes", strobe_cnt, sc);
        chk("p80_oe", oe_cnt, oc);
`endif

        repeat (4) cyc(1'b1, 4'hF);
        chk("stb_queue_drained", stb_q.size(), 32'd0);
        chk("lad_queue_drained", lad_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
